// File: rtl/hack_mem_pkg.sv
// Shared constants, region enum and address decode for the Hack data memory.
package hack_mem_pkg;

    localparam int RAM_WORDS    = 16384;
    localparam int SCREEN_WORDS = 8192;

    localparam logic [14:0] RAM_BASE    = 15'h0000;
    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_NONE
    } region_e;

    // Full 15-bit decode; anything outside the three regions is unmapped.
    function automatic region_e decode_region(input logic [14:0] addr);
        if (addr < RAM_BASE + 15'(RAM_WORDS))
            return REG_RAM;
        else if (addr >= SCREEN_BASE && addr < SCREEN_BASE + 15'(SCREEN_WORDS))
            return REG_SCREEN;
        else if (addr == KBD_ADDR)
            return REG_KBD;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_data_memory_if.sv
// CPU data bus between the Hack CPU (master) and the data memory (slave).
interface hack_data_memory_if;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;

    modport master (output addressM, output outM, output writeM, input inM);
    modport slave  (input addressM, input outM, input writeM, output inM);
endinterface

// File: rtl/hack_screen_buf.sv
// Dual-port 8K x 16 screen buffer.
// Port A (CPU): combinational read, synchronous write.
// Port B (scan): registered read; reads the old word when port A writes it
// on the same edge.
module hack_screen_buf
    import hack_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] a_addr_i,
    input  logic [15:0] a_wdata_i,
    input  logic        a_we_i,
    output logic [15:0] a_rdata_o,
    input  logic [12:0] b_addr_i,
    input  logic        b_en_i,
    output logic [15:0] b_rdata_o
);

    logic [15:0] mem_q [SCREEN_WORDS];
    logic [15:0] b_rdata_q;

    // CPU write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    end

    assign a_rdata_o = mem_q[a_addr_i];

    // Scan read; non-blocking semantics give read-before-write on collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      b_rdata_q <= '0;
        else if (b_en_i) b_rdata_q <= mem_q[b_addr_i];
    end

    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: 16K RAM, 8K screen buffer, keyboard register and a
// screen scan-out engine. Optional macro HACK_MEM_ERR_EN adds bad_access /
// bad_count reporting of writes to the keyboard or unmapped addresses.
module hack_data_memory
    import hack_mem_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    hack_data_memory_if.slave        bus,
    input  logic                     kbd_valid,
    input  logic [15:0]              kbd_code,
    input  logic                     scan_en,
    output logic [15:0]              scan_word,
    output logic                     scan_valid,
    output logic                     scan_last
`ifdef HACK_MEM_ERR_EN
   ,output logic                     bad_access,
    output logic [7:0]               bad_count
`endif
);

    region_e     region;
    logic [15:0] ram_q [RAM_WORDS];
    logic [15:0] scr_rdata;
    logic [15:0] kbd_q;
    logic [12:0] scan_ptr_q, scan_ptr_d;
    logic        scan_valid_q, scan_last_q;

    assign region = decode_region(bus.addressM);

    // General RAM write; contents are not reset.
    always_ff @(posedge clk) begin
        if (bus.writeM && region == REG_RAM) ram_q[bus.addressM[13:0]] <= bus.outM;
    end

    hack_screen_buf u_scr (
        .clk       (clk),
        .reset     (reset),
        .a_addr_i  (bus.addressM[12:0]),
        .a_wdata_i (bus.outM),
        .a_we_i    (bus.writeM && region == REG_SCREEN),
        .a_rdata_o (scr_rdata),
        .b_addr_i  (scan_ptr_q),
        .b_en_i    (scan_en),
        .b_rdata_o (scan_word)
    );

    // Zero-latency read mux for the single-cycle CPU.
    always_comb begin
        bus.inM = '0;
        case (region)
            REG_RAM:    bus.inM = ram_q[bus.addressM[13:0]];
            REG_SCREEN: bus.inM = scr_rdata;
            REG_KBD:    bus.inM = kbd_q;
            default:    bus.inM = '0;
        endcase
    end

    // Keyboard register loads on strobe, holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         kbd_q <= '0;
        else if (kbd_valid) kbd_q <= kbd_code;
    end

    assign scan_ptr_d = (scan_ptr_q == 13'(SCREEN_WORDS - 1)) ? '0 : scan_ptr_q + 13'd1;

    // Scan pointer plus the valid/last flags that accompany the read stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_ptr_q   <= '0;
            scan_valid_q <= 1'b0;
            scan_last_q  <= 1'b0;
        end else begin
            scan_valid_q <= scan_en;
            scan_last_q  <= scan_en && (scan_ptr_q == 13'(SCREEN_WORDS - 1));
            if (scan_en) scan_ptr_q <= scan_ptr_d;
        end
    end

    assign scan_valid = scan_valid_q;
    assign scan_last  = scan_last_q;

`ifdef HACK_MEM_ERR_EN
    logic       bad_wr;
    logic       bad_access_q;
    logic [7:0] bad_count_q;

    assign bad_wr = bus.writeM && (region == REG_KBD || region == REG_NONE);

    // Sticky flag and saturating counter for writes that land nowhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_access_q <= 1'b0;
            bad_count_q  <= '0;
        end else if (bad_wr) begin
            bad_access_q <= 1'b1;
            if (bad_count_q != 8'hFF) bad_count_q <= bad_count_q + 8'd1;
        end
    end

    assign bad_access = bad_access_q;
    assign bad_count  = bad_count_q;
`endif

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Memory-side responder for the Hack CPU data bus. It answers the addressM/outM/writeM requests the CPU initiates and returns inM.
- Implements the full Hack data memory map:
  - 16K-word RAM,
  - 8K-word screen buffer,
  - keyboard register.
- Adds a display scan-out engine that streams the screen buffer to a video back end.
- Sits beside the CPU inside the computer top, replacing a bare RAM.

Parameters:
- RAM_WORDS, 16384, number of general RAM words (addresses 0x0000..RAM_WORDS-1).
- SCREEN_WORDS, 8192, number of screen buffer words (addresses 0x4000..0x5FFF).
- KBD_ADDR, 15'h6000, address of the keyboard register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- addressM  input  15  CPU data address.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write enable for the current cycle.
- inM  output  16  read data for addressM (combinational).
- kbd_valid  input  1  keyboard code strobe.
- kbd_code  input  16  key code; 0 means no key pressed.
- scan_en  input  1  advance the scan engine this cycle.
- scan_word  output  16  screen word read by the scan engine.
- scan_valid  output  1  scan_word is valid this cycle.
- scan_last  output  1  scan_word is screen word SCREEN_WORDS-1.

Behaviour:
- Address decode:
  - 0x0000-0x3FFF selects RAM.
  - 0x4000-0x5FFF selects the screen buffer (index = addressM[12:0]).
  - 0x6000 selects the keyboard register.
  - 0x6001-0x7FFF is unmapped.
- CPU reads:
  - inM is a combinational function of addressM and current contents, with zero-cycle latency (required by the single-cycle Hack CPU).
  - Unmapped reads return 16'h0000.
- CPU writes:
  - When writeM=1, outM is stored at the rising clk edge into RAM or the screen buffer.
  - Writes to the keyboard or unmapped addresses are ignored.
  - A read of the same address in the cycle after a write returns the new data.
- Keyboard register:
  - Loads kbd_code on any rising edge where kbd_valid=1; otherwise holds.
  - Reset value 0. kbd_valid during reset is ignored.
- Scan engine (pipeline of one read stage):
  - Internal pointer scan_ptr (13 bits), reset value 0.
  - On an edge with scan_en=1: read screen[scan_ptr], and scan_ptr <= scan_ptr+1, wrapping from SCREEN_WORDS-1 to 0.
  - On the following cycle: scan_valid=1, scan_word = data read, scan_last = 1 if the pointer read was SCREEN_WORDS-1.
  - On an edge with scan_en=0: the pointer holds, and next cycle scan_valid=0 and scan_last=0. scan_word holds its last value.
- Read/write collision: a CPU write and a scan read of the same screen word on the same edge returns the OLD word to the scan port (read-before-write). The CPU port always sees the new word afterwards.
- Reset:
  - Outputs: scan_valid=0, scan_last=0, scan_word=0.
  - Registers: scan_ptr=0, keyboard=0.
  - RAM and screen contents are not reset (undefined until written).
  - Reset asserted mid-scan abandons the frame; after release, scanning restarts at word 0.
- Width rules:
  - The address is 15 bits; no bits are ignored except within the decoded ranges.
  - Arithmetic is limited to the 13-bit wrapping increment.

Optional Feature:
- Macro: HACK_MEM_ERR_EN.
- When defined:
  - Adds output bad_access (1 bit) and output bad_count (8 bits).
  - bad_access is sticky. It sets on any edge with writeM=1 to the keyboard or an unmapped address. It clears only on reset.
  - bad_count increments on each such write and saturates at 255. Reset value 0.
- When undefined: neither port nor its logic exists, and such writes are silently ignored.

Decomposition:
- Package hack_mem_pkg holds:
  - RAM_BASE, SCREEN_BASE, KBD_ADDR;
  - RAM_WORDS, SCREEN_WORDS;
  - a region enum: REG_RAM, REG_SCREEN, REG_KBD, REG_NONE.
- One sub-module, hack_screen_buf: a dual-port 8K×16 memory.
  - Port A: CPU, with combinational read and synchronous write.
  - Port B: scan, with synchronous read-before-write.
- RAM, decode, keyboard register and scan engine live in the top.

Test Plan:
- Write 16'h1234 to RAM 0x0005, then read 0x0005 the next cycle -> inM=16'h1234. Read 0x3FFF after writing 16'hBEEF there -> 16'hBEEF.
- Pulse kbd_valid with kbd_code=16'h0041, then read 0x6000 -> inM=16'h0041. Write 16'hFFFF to 0x6000 -> still 16'h0041. Read 0x7000 -> 16'h0000.
- Fill screen word i with i for all 8192 words, hold scan_en=1 from reset release:
  - scan_valid first rises one cycle later with scan_word=0;
  - word 8191 carries scan_last=1;
  - the next scan_word is 0 (wrap).
- CPU writes 16'hAAAA to 0x4010 on the same edge the scan reads index 0x10 (old value 16'h5555) -> scan_word=16'h5555, and inM at 0x4010 afterwards = 16'hAAAA.
- Drop scan_en for 3 cycles mid-frame -> scan_valid=0 for those cycles, and the stream resumes at the next index with no skip or repeat.
- With HACK_MEM_ERR_EN: three writes to 0x6005, then reset low mid-scan -> bad_count=3 and bad_access=1 before reset. After reset release: both are 0, scan_ptr=0, and the keyboard reads 0.
